drag_race_lane_controller: RTL and testbench

Two-lane race controller for the drag-race christmas tree. It waits until both lanes are staged, then sequences one shared amber countdown. It issues a per-lane green or red (foul), measures each lane's reaction time and elapsed time in millisecond ticks, and declares the winner. It sits between the beam sensors and the tree/scoreboard lamps, and replaces per-lane stand-alone tree logic when two cars race head to head.

---
 rtl/drag_race_lane_controller_if.sv | 31 +++
 rtl/drag_race_lane_controller.sv | 174 +++++++++++++++++
 tb/tb_drag_race_lane_controller.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/drag_race_lane_controller_if.sv
// Beam sensor inputs and tree/scoreboard lamp outputs of the two-lane race controller.
interface drag_race_lane_controller_if #(
   parameter int TW = 16
);
   logic [1:0]    psb;
   logic [1:0]    sb;
   logic [1:0]    fb;
   logic [1:0]    psl;
   logic [1:0]    sl;
   logic          a1;
   logic          a2;
   logic          a3;
   logic [1:0]    g;
   logic [1:0]    r;
   logic [TW-1:0] rt0;
   logic [TW-1:0] rt1;
   logic [TW-1:0] et0;
   logic [TW-1:0] et1;
   logic          done;
   logic [1:0]    winner;

   modport master (
      output psb, sb, fb,
      input  psl, sl, a1, a2, a3, g, r, rt0, rt1, et0, et1, done, winner
   );

   modport slave (
      input  psb, sb, fb,
      output psl, sl, a1, a2, a3, g, r, rt0, rt1, et0, et1, done, winner
   );
endinterface

// File: rtl/drag_race_lane_controller.sv
// Two-lane drag-race tree: staging, shared amber countdown, per-lane foul/green, ms timing, winner.
// DRCC_PRO_TREE_EN selects the pro tree (single all-amber step) instead of the sportsman countdown.
module drag_race_lane_controller #(
   parameter int STAGE_CYCLES = 50_000_000,
   parameter int AMBER_CYCLES = 25_000_000,
   parameter int PRO_CYCLES   = 20_000_000,
   parameter int TICK_CYCLES  = 50_000,
   parameter int TIMEOUT_MS   = 20_000,
   parameter int TW           = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   drag_race_lane_controller_if.slave lanes_io
);

   // One counter serves staging, amber steps and the ms tick prescaler, so size it for the longest.
   localparam int MAX_SA = (STAGE_CYCLES > AMBER_CYCLES) ? STAGE_CYCLES : AMBER_CYCLES;
   localparam int MAX_PT = (PRO_CYCLES > TICK_CYCLES) ? PRO_CYCLES : TICK_CYCLES;
   localparam int MAX_C  = (MAX_SA > MAX_PT) ? MAX_SA : MAX_PT;
   localparam int CW     = $clog2(MAX_C + 1);

   typedef enum logic [2:0] {
      IDLE, STAGE, AMB1, AMB2, AMB3,
`ifdef DRCC_PRO_TREE_EN
      AMBP,
`endif
      RACE, DONE
   } state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [TW-1:0] ms_q;
   logic [1:0]    foul_q, fin_q, rt_cap_q, sb_prev_q, fb_prev_q;
   logic          a1_q, a2_q, a3_q, done_q;
   logic [1:0]    g_q, r_q, winner_q;
   logic [TW-1:0] rt0_q, rt1_q, et0_q, et1_q;

   logic [1:0]    sb, fb, foul_d, fall, rise, rt_hit, fin_now, fin_d;
   logic          amber, tick, timeout;
   logic [CW-1:0] amber_last;
   state_t        amber_next;

   assign sb      = lanes_io.sb;
   assign fb      = lanes_io.fb;
   assign fall    = sb_prev_q & ~sb;
   assign rise    = ~fb_prev_q & fb;
   assign rt_hit  = fall & ~rt_cap_q;
   assign fin_now = rise & ~foul_q & ~fin_q;
   assign fin_d   = fin_q | fin_now;
   assign tick    = (cnt_q == CW'(TICK_CYCLES - 1));
   assign timeout = (ms_q >= TW'(TIMEOUT_MS));
   assign foul_d  = foul_q | (amber ? ~sb : 2'b00);

   always_comb begin
      amber      = 1'b0;
      amber_last = CW'(AMBER_CYCLES - 1);
      amber_next = RACE;
      case (state_q)
         AMB1: begin amber = 1'b1; amber_next = AMB2; end
         AMB2: begin amber = 1'b1; amber_next = AMB3; end
         AMB3: begin amber = 1'b1; amber_next = RACE; end
`ifdef DRCC_PRO_TREE_EN
         AMBP: begin amber = 1'b1; amber_last = CW'(PRO_CYCLES - 1); end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         ms_q      <= '0;
         foul_q    <= '0;
         fin_q     <= '0;
         rt_cap_q  <= '0;
         sb_prev_q <= '0;
         fb_prev_q <= '0;
         a1_q      <= 1'b0;
         a2_q      <= 1'b0;
         a3_q      <= 1'b0;
         done_q    <= 1'b0;
         g_q       <= '0;
         r_q       <= '0;
         winner_q  <= '0;
         rt0_q     <= '0;
         rt1_q     <= '0;
         et0_q     <= '0;
         et1_q     <= '0;
      end else begin
         sb_prev_q <= sb;
         fb_prev_q <= fb;
         done_q    <= (state_q == DONE);
         if (amber) begin
            foul_q <= foul_d;
            r_q    <= foul_d;
            if (&foul_d) begin
               state_q <= DONE;
               {a1_q, a2_q, a3_q} <= 3'b000;
            end else if (cnt_q == amber_last) begin
               cnt_q   <= '0;
               state_q <= amber_next;
               {a1_q, a2_q, a3_q} <= {1'b0, amber_next == AMB2, amber_next == AMB3};
               if (amber_next == RACE) begin
                  g_q  <= ~foul_d;
                  ms_q <= '0;
               end
            end else begin
               cnt_q <= cnt_q + CW'(1);
            end
         end
         case (state_q)
            IDLE: if (sb == 2'b11) begin
               state_q <= STAGE;
               cnt_q   <= '0;
            end
            STAGE: begin
               if (sb != 2'b11) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else if (cnt_q == CW'(STAGE_CYCLES - 1)) begin
                  cnt_q <= '0;
`ifdef DRCC_PRO_TREE_EN
                  state_q <= AMBP;
                  {a1_q, a2_q, a3_q} <= 3'b111;
`else
                  state_q <= AMB1;
                  a1_q    <= 1'b1;
`endif
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            RACE: begin
               cnt_q <= tick ? '0 : cnt_q + CW'(1);
               if (tick && (ms_q != '1)) ms_q <= ms_q + TW'(1);
               if (rt_hit[0]) rt0_q <= ms_q;
               if (rt_hit[1]) rt1_q <= ms_q;
               if (fin_now[0]) et0_q <= ms_q;
               if (fin_now[1]) et1_q <= ms_q;
               rt_cap_q <= rt_cap_q | rt_hit;
               fin_q    <= fin_d;
               // Simultaneous first finishes encode naturally as 2'b11.
               if ((winner_q == 2'b00) && (fin_now != 2'b00)) winner_q <= fin_now;
               if ((fin_d | foul_q) == 2'b11) begin
                  state_q <= DONE;
               end else if (timeout) begin
                  state_q <= DONE;
                  if (!fin_d[0]) et0_q <= '1;
                  if (!fin_d[1]) et1_q <= '1;
                  if (!(rt_cap_q[0] | rt_hit[0])) rt0_q <= '1;
                  if (!(rt_cap_q[1] | rt_hit[1])) rt1_q <= '1;
               end
            end
            default: ;
         endcase
      end
   end

   assign lanes_io.psl    = lanes_io.psb;
   assign lanes_io.sl     = lanes_io.sb;
   assign lanes_io.a1     = a1_q;
   assign lanes_io.a2     = a2_q;
   assign lanes_io.a3     = a3_q;
   assign lanes_io.g      = g_q;
   assign lanes_io.r      = r_q;
   assign lanes_io.rt0    = rt0_q;
   assign lanes_io.rt1    = rt1_q;
   assign lanes_io.et0    = et0_q;
   assign lanes_io.et1    = et1_q;
   assign lanes_io.done   = done_q;
   assign lanes_io.winner = winner_q;

endmodule

// File: tb/tb_drag_race_lane_controller.sv
// Bench for drag_race_lane_controller: directed and random races checked against an event-time model.
module tb_drag_race_lane_controller;
   localparam int S  = 10;
   localparam int A  = 5;
   localparam int P  = 7;
   localparam int T  = 2;
   localparam int TO = 100;
`ifdef DRCC_PRO_TREE_EN
   localparam int EG = S + P + 1;
`else
   localparam int EG = S + 3 * A + 1;
`endif
   localparam int NONE = 1 << 30;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   tests = 0;
   int   fails = 0;
   int   cur_k = 0;

   bit [1:0] fl, dv, fv;
   int       fk[2], d[2], f[2];

   drag_race_lane_controller_if #(.TW(16)) bus ();

   drag_race_lane_controller #(
      .STAGE_CYCLES(S), .AMBER_CYCLES(A), .PRO_CYCLES(P),
      .TICK_CYCLES(T), .TIMEOUT_MS(TO), .TW(16)
   ) dut (
      .clk_i(clk), .rst_i(rst), .lanes_io(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s at step %0d: observed %0h expected %0h", tag, cur_k, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_amb"}, {29'd0, bus.a1, bus.a2, bus.a3}, 32'd0);
      chk({tag, "_g"}, {30'd0, bus.g}, 32'd0);
      chk({tag, "_r"}, {30'd0, bus.r}, 32'd0);
      chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
      chk({tag, "_win"}, {30'd0, bus.winner}, 32'd0);
      chk({tag, "_times"}, {bus.rt0 | bus.rt1, bus.et0 | bus.et1}, 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.sb = 2'b00; bus.fb = 2'b00; bus.psb = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      cur_k = 0;
      chk_zero("reset");
      rst = 1'b0;
   endtask

   // Amber lamps {A1,A2,A3} expected after the k-th edge counted from SB=11 being presented.
   function automatic logic [2:0] amb_exp(input int k);
`ifdef DRCC_PRO_TREE_EN
      return (k >= S + 1 && k <= S + P) ? 3'b111 : 3'b000;
`else
      return {k >= S + 1 && k <= S + A,
              k >= S + A + 1 && k <= S + 2 * A,
              k >= S + 2 * A + 1 && k <= S + 3 * A};
`endif
   endfunction

   task automatic set_scn(input bit [1:0] fl_i, input int fk0, input int fk1,
                          input bit [1:0] dv_i, input int d0, input int d1,
                          input bit [1:0] fv_i, input int f0, input int f1);
      fl = fl_i; fk[0] = fk0; fk[1] = fk1;
      dv = dv_i; d[0] = d0; d[1] = d1;
      fv = fv_i; f[0] = f0; f[1] = f1;
   endtask

   // Race cycle c = k-EG-1 is the RACE cycle closed by edge k; in it the ms count is c/T.
   task automatic run_scn(input int stop_k);
      bit        dbl, to;
      int        dk, c_end, fmin, last_k, c;
      logic [1:0]  win_e, cap, fo, sb_v, fb_v;
      logic [15:0] rt_e[2], et_e[2];
      dbl   = fl[0] && fl[1];
      dk    = (fk[0] > fk[1]) ? fk[0] : fk[1];
      to    = 1'b0;
      c_end = 0;
      fmin  = NONE;
      win_e = 2'b00;
      for (int l = 0; l < 2; l++) begin
         if (!fl[l]) begin
            if (!fv[l]) to = 1'b1;
            else begin
               if (f[l] > c_end) c_end = f[l];
               if (f[l] < fmin) fmin = f[l];
            end
         end
      end
      if (to) c_end = T * TO;
      for (int l = 0; l < 2; l++) begin
         win_e[l] = !fl[l] && fv[l] && (f[l] == fmin);
         cap[l]   = dv[l] && !fl[l] && (d[l] <= c_end);
      end
      last_k = dbl ? dk + 3 : EG + c_end + 4;
      do_reset();
      for (int k = 1; k <= last_k; k++) begin
         cur_k = k;
         c = k - EG - 1;
         if (k == stop_k) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            chk_zero("midrace_reset");
            rst = 1'b0;
            return;
         end
         for (int l = 0; l < 2; l++) begin
            sb_v[l] = !((fl[l] && k >= fk[l]) || (!dbl && c >= 0 && dv[l] && c >= d[l]));
            fb_v[l] = !dbl && c >= 0 && fv[l] && c >= f[l];
         end
         bus.sb  = sb_v;
         bus.fb  = fb_v;
         bus.psb = 2'($urandom);
         #1;
         chk("psl", {30'd0, bus.psl}, {30'd0, bus.psb});
         chk("sl", {30'd0, bus.sl}, {30'd0, sb_v});
         @(posedge clk);
         #1;
         for (int l = 0; l < 2; l++) begin
            fo[l]   = fl[l] && k >= fk[l];
            rt_e[l] = 16'd0;
            et_e[l] = 16'd0;
            if (!dbl && c >= 0) begin
               if (cap[l] && c >= d[l]) rt_e[l] = 16'(d[l] / T);
               else if (to && c >= T * TO) rt_e[l] = 16'hFFFF;
               if (!fl[l] && fv[l] && c >= f[l]) et_e[l] = 16'(f[l] / T);
               else if (to && c >= T * TO) et_e[l] = 16'hFFFF;
            end
         end
         chk("amber", {29'd0, bus.a1, bus.a2, bus.a3},
             {29'd0, (dbl && k >= dk) ? 3'b000 : amb_exp(k)});
         chk("red", {30'd0, bus.r}, {30'd0, fo});
         chk("green", {30'd0, bus.g}, {30'd0, (!dbl && k >= EG) ? ~fl : 2'b00});
         chk("rt0", {16'd0, bus.rt0}, {16'd0, rt_e[0]});
         chk("rt1", {16'd0, bus.rt1}, {16'd0, rt_e[1]});
         chk("et0", {16'd0, bus.et0}, {16'd0, et_e[0]});
         chk("et1", {16'd0, bus.et1}, {16'd0, et_e[1]});
         chk("winner", {30'd0, bus.winner},
             {30'd0, (!dbl && fmin != NONE && c >= fmin) ? win_e : 2'b00});
         chk("done", {31'd0, bus.done},
             {31'd0, dbl ? (k >= dk + 1) : (c >= c_end + 1)});
      end
   endtask

   initial begin
      bus.sb = 2'b00; bus.fb = 2'b00; bus.psb = 2'b00;

      // Staging abort: lane 1 leaves stage after 6 cycles; nothing may light afterwards.
      do_reset();
      for (int k = 1; k <= 30; k++) begin
         cur_k = k;
         bus.sb = (k <= 6) ? 2'b11 : 2'b01;
         @(posedge clk);
         #1;
         chk("abort_amber", {29'd0, bus.a1, bus.a2, bus.a3}, 32'd0);
         chk("abort_red", {30'd0, bus.r}, 32'd0);
         chk("abort_green", {30'd0, bus.g}, 32'd0);
      end

      // Clean race: RT0=2, RT1=4, ET0=20, ET1=30, Winner=01.
      set_scn(2'b00, 0, 0, 2'b11, 4, 8, 2'b11, 40, 60);
      run_scn(0);
      // Lane 1 fouls in AMB2; its later FB is ignored.
      set_scn(2'b10, 0, S + A + 2, 2'b01, 3, 0, 2'b11, 50, 30);
      run_scn(0);
      // Double foul in AMB1.
      set_scn(2'b11, S + 2, S + 2, 2'b00, 0, 0, 2'b00, 0, 0);
      run_scn(0);
      // Tie.
      set_scn(2'b00, 0, 0, 2'b11, 10, 10, 2'b11, 70, 70);
      run_scn(0);
      // Timeout with nobody finishing.
      set_scn(2'b00, 0, 0, 2'b11, 3, 5, 2'b00, 0, 0);
      run_scn(0);
      // Foul on the very last amber edge still withholds green.
      set_scn(2'b01, EG, 0, 2'b10, 0, 6, 2'b10, 0, 90);
      run_scn(0);
      // Reset mid-race.
      set_scn(2'b00, 0, 0, 2'b11, 4, 8, 2'b11, 40, 60);
      run_scn(EG + 30);

      for (int n = 0; n < 20; n++) begin
         bit [1:0] rfl, rdv, rfv;
         int rfk0, rfk1, rd0, rd1, rf0, rf1;
         rfl  = {($urandom_range(3) == 0), ($urandom_range(3) == 0)};
         rfk0 = $urandom_range(EG, S + 2);
         rfk1 = $urandom_range(EG, S + 2);
         rdv  = {($urandom_range(3) != 0), ($urandom_range(3) != 0)};
         rfv  = {($urandom_range(3) != 0), ($urandom_range(3) != 0)};
         rd0  = $urandom_range(150, 0);
         rd1  = $urandom_range(150, 0);
         rf0  = $urandom_range(199, rdv[0] ? rd0 + 1 : 1);
         rf1  = ($urandom_range(4) == 0) ? rf0 : $urandom_range(199, rdv[1] ? rd1 + 1 : 1);
         set_scn(rfl, rfk0, rfk1, rdv, rd0, rd1, rfv, rf0, rf1);
         run_scn(0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
